// File: rtl/id_ex_stage_buf.sv
// ID/EX pipeline stage: 2-entry skid buffer with valid/ready handshake, flush,
// NOP control word on bubbles, and saturating stall/bubble counters.
module id_ex_stage_buf #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CTRL_W     = 11,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned PAY_W     = 5*DATA_W + 3*REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PAY_W-1:0]  in_payload,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PAY_W-1:0]  out_payload,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              clr_counters,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  state_t            state, state_n;
  logic [PAY_W-1:0]  main_payload, skid_payload;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              accept, consume;
  logic              load_in, load_from_skid, load_skid, go_empty;

  assign in_ready    = (state != SKID) & ~reset;
  assign out_valid   = (state != EMPTY);
  assign out_payload = main_payload;
  assign out_ctrl    = main_ctrl;
  assign accept      = in_valid & in_ready;
  assign consume     = out_valid & out_ready;

  always_comb begin
    state_n        = state;
    load_in        = 1'b0;
    load_from_skid = 1'b0;
    load_skid      = 1'b0;
    go_empty       = 1'b0;
    if (flush) begin
      state_n  = EMPTY;
      go_empty = 1'b1;
    end else begin
      unique case (state)
        EMPTY: if (accept) begin
          state_n = FULL;
          load_in = 1'b1;
        end
        FULL: begin
          if (accept && consume) begin
            load_in = 1'b1;
          end else if (accept) begin
            state_n   = SKID;
            load_skid = 1'b1;
          end else if (consume) begin
            state_n  = EMPTY;
            go_empty = 1'b1;
          end
        end
        SKID: if (consume) begin
          state_n        = FULL;
          load_from_skid = 1'b1;
        end
        default: begin
          state_n  = EMPTY;
          go_empty = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= EMPTY;
      main_payload <= '0;
      main_ctrl    <= NOP_CTRL;
      skid_payload <= '0;
      skid_ctrl    <= '0;
    end else begin
      state <= state_n;
      if (load_in) begin
        main_payload <= in_payload;
        main_ctrl    <= in_ctrl;
      end else if (load_from_skid) begin
        main_payload <= skid_payload;
        main_ctrl    <= skid_ctrl;
      end else if (go_empty) begin
        // payload is left as-is on bubbles; only the control word is neutralised
        main_ctrl <= NOP_CTRL;
      end
      if (flush) begin
        skid_payload <= '0;
        skid_ctrl    <= '0;
      end else if (load_skid) begin
        skid_payload <= in_payload;
        skid_ctrl    <= in_ctrl;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count  <= '0;
      bubble_count <= '0;
    end else if (clr_counters) begin
      stall_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (out_valid && !out_ready && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
      if (!out_valid && bubble_count != '1)
        bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule
